parity_nibble_rx: RTL and testbench

PARITY_NIBBLE_RX -- requirements
Module: parity_nibble_rx

---
 rtl/parity_pkg.sv | 14 +
 rtl/xor_prefix4.sv | 12 +
 rtl/parity_nibble_rx.sv | 96 +++++++++
 tb/tb_parity_nibble_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and sizing for the serial nibble receiver with parity check.
// Frame = FRAME_DATA_BITS data bits (LSB first) followed by one parity bit.
package parity_pkg;

    localparam int FRAME_DATA_BITS = 4;
    localparam int CNT_W           = $clog2(FRAME_DATA_BITS);

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_PAR  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/xor_prefix4.sv
// Combinational prefix-XOR over a 4-bit nibble: running parity after d1, d2, d3.
module xor_prefix4 (
    input  logic [3:0] d,
    output logic [2:0] p
);

    // Each term is written out in full to keep the vector free of self-reference.
    assign p[0] = d[0] ^ d[1];
    assign p[1] = d[0] ^ d[1] ^ d[2];
    assign p[2] = d[0] ^ d[1] ^ d[2] ^ d[3];

endmodule

// File: rtl/parity_nibble_rx.sv
// Serial nibble receiver: collects 4 data bits and a parity bit, then holds the
// frame with a parity-error flag until the consumer handshakes it away.
module parity_nibble_rx
    import parity_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FRAME_DATA_BITS-1:0] out_data,
    output logic [2:0]                 out_prefix,
    output logic                       out_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DATA_BITS - 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       acc_q, acc_d;
    logic [FRAME_DATA_BITS-1:0] data_q, data_d;
    logic                       err_q, err_d;
    logic                       accept;

    // State register; reset wins over any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign accept = in_valid && in_ready;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DATA:  if (accept && cnt_q == CNT_LAST) state_d = S_PAR;
            S_PAR:   if (accept) state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_DATA;
            default: state_d = S_DATA;
        endcase
    end

    // Datapath updates; idle cycles leave everything untouched.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        data_d = data_q;
        err_d  = err_q;
        case (state_q)
            S_DATA: begin
                if (accept) begin
                    data_d[cnt_q] = in_bit;
                    acc_d         = acc_q ^ in_bit;
                    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            S_PAR: begin
                if (accept) err_d = acc_q ^ in_bit ^ PARITY_ODD;
            end
            S_HOLD: begin
                if (out_ready) acc_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Output logic: in_ready only returns the cycle after the hold handshake.
    always_comb begin
        in_ready  = (state_q != S_HOLD);
        out_valid = (state_q == S_HOLD);
        out_data  = data_q;
        out_err   = err_q;
    end

    xor_prefix4 u_prefix (
        .d (data_q),
        .p (out_prefix)
    );

endmodule

// File: tb/tb_parity_nibble_rx.sv
// Directed bench for parity_nibble_rx: even-parity instance plus an odd-parity twin.
module tb_parity_nibble_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       out_ready;
    logic       in_ready,  out_valid,  out_err;
    logic [3:0] out_data;
    logic [2:0] out_prefix;
    logic       in_ready_o, out_valid_o, out_err_o;
    logic [3:0] out_data_o;
    logic [2:0] out_prefix_o;

    int total = 0;
    int bad   = 0;
    int vseen;

    always #5 clk = ~clk;

    parity_nibble_rx #(.PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_prefix(out_prefix), .out_err(out_err)
    );

    parity_nibble_rx #(.PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_o), .out_valid(out_valid_o), .out_ready(out_ready),
        .out_data(out_data_o), .out_prefix(out_prefix_o), .out_err(out_err_o)
    );

    // One clock step; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one bit per cycle; counts cycles where out_valid was seen early.
    task automatic send_frame(input logic [3:0] d, input logic p);
        logic [4:0] bits;
        bits  = {p, d};
        vseen = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            step();
            if (i < 4 && out_valid) vseen++;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
        step(); step();
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_data !== 4'b0000) begin bad++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_frame(4'b1101, 1'b1);
        total++; if (vseen !== 0) begin bad++; $display("FAIL basic_early_valid got=%0d exp=0", vseen); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 4'b1101) begin bad++; $display("FAIL basic_out_data got=%b exp=1101", out_data); end
        total++; if (out_prefix !== 3'b101) begin bad++; $display("FAIL basic_out_prefix got=%b exp=101", out_prefix); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL basic_out_err got=%b exp=0", out_err); end
        total++; if (out_err_o !== 1'b1) begin bad++; $display("FAIL basic_odd_err got=%b exp=1", out_err_o); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_in_ready got=%b exp=0", in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_parity_err();
        out_ready = 1'b1;
        send_frame(4'b1101, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL perr_out_valid got=%b exp=1", out_valid); end
        total++; if (out_err !== 1'b1) begin bad++; $display("FAIL perr_even_err got=%b exp=1", out_err); end
        total++; if (out_err_o !== 1'b0) begin bad++; $display("FAIL perr_odd_err got=%b exp=0", out_err_o); end
        total++; if (out_data_o !== 4'b1101) begin bad++; $display("FAIL perr_odd_data got=%b exp=1101", out_data_o); end
        step();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        send_frame(4'b1101, 1'b1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_bit   = c[0];
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== 4'b1101 || out_err !== 1'b0 ||
                out_prefix !== 3'b101 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got v=%b d=%b e=%b p=%b r=%b exp v=1 d=1101 e=0 p=101 r=0",
                         c, out_valid, out_data, out_err, out_prefix, in_ready);
            end
        end
        // A bit offered on the handshake edge must not be taken.
        in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_bit = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", out_valid); end
        send_frame(4'b0110, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_next_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 4'b0110) begin bad++; $display("FAIL hold_next_data got=%b exp=0110", out_data); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL hold_next_err got=%b exp=0", out_err); end
        step();
    endtask

    task automatic test_gaps();
        logic [4:0] bits;
        bits      = 5'b0_0110;
        out_ready = 1'b1;
        vseen     = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_bit = bits[i];
            step();
            if (i < 4 && out_valid) vseen++;
            if (i < 4) begin
                in_valid = 1'b0; in_bit = ~bits[i];
                step(); if (out_valid) vseen++;
                step(); if (out_valid) vseen++;
            end
        end
        in_valid = 1'b0; in_bit = 1'b0;
        total++; if (vseen !== 0) begin bad++; $display("FAIL gaps_early_valid got=%0d exp=0", vseen); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gaps_out_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 4'b0110) begin bad++; $display("FAIL gaps_out_data got=%b exp=0110", out_data); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL gaps_out_err got=%b exp=0", out_err); end
        step();
    endtask

    task automatic test_reset_mid();
        int vcount;
        out_ready = 1'b1;
        vcount    = 0;
        in_valid  = 1'b1; in_bit = 1'b1; step();
        in_valid  = 1'b1; in_bit = 1'b1; step();
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
        step();
        rst = 1'b0; in_valid = 1'b0;
        if (out_valid) vcount++;
        send_frame(4'b1000, 1'b1);
        vcount += vseen;
        if (out_valid) vcount++;
        total++; if (out_data !== 4'b1000) begin bad++; $display("FAIL rstmid_out_data got=%b exp=1000", out_data); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rstmid_out_err got=%b exp=0", out_err); end
        step(); if (out_valid) vcount++;
        step(); if (out_valid) vcount++;
        total++; if (vcount !== 1) begin bad++; $display("FAIL rstmid_valid_count got=%0d exp=1", vcount); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fd [3];
        logic       fp [3];
        logic [4:0] cur;
        int         fi, bi, nv;
        int         vcyc [3];
        fd[0] = 4'b1101; fp[0] = 1'b1;
        fd[1] = 4'b0110; fp[1] = 1'b0;
        fd[2] = 4'b1000; fp[2] = 1'b0;
        fi = 0; bi = 0; nv = 0;
        out_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (in_ready && fi < 3) begin
                cur      = {fp[fi], fd[fi]};
                in_valid = 1'b1;
                in_bit   = cur[bi];
                bi++;
                if (bi == 5) begin bi = 0; fi++; end
            end else begin
                in_valid = 1'b0; in_bit = 1'b0;
            end
            step();
            if (out_valid) begin
                if (nv < 3) begin
                    vcyc[nv] = c;
                    total++;
                    if (out_data !== fd[nv] || out_err !== (^fd[nv] ^ fp[nv])) begin
                        bad++;
                        $display("FAIL b2b_frame%0d got d=%b e=%b exp d=%b e=%b",
                                 nv, out_data, out_err, fd[nv], ^fd[nv] ^ fp[nv]);
                    end
                end
                nv++;
            end
        end
        in_valid = 1'b0;
        total++; if (nv !== 3) begin bad++; $display("FAIL b2b_valid_count got=%0d exp=3", nv); end
        if (nv == 3) begin
            total++;
            if (vcyc[0] !== 5 || vcyc[1] !== 11 || vcyc[2] !== 17) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=5,11,17", vcyc[0], vcyc[1], vcyc[2]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_parity_err();
        test_hold();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
